// File: rtl/shift_pkg.sv
// Shared types and defaults for the serial shift sequencer.
package shift_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned AMT_W_DEF = 4;
  localparam int unsigned STATE_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    SHL1 = 3'd1,
    SHR  = 3'd2,
    SHL2 = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Control-unit <-> shift sequencer handshake and operand bus.
interface shift_sequencer_if #(
  parameter int unsigned WIDTH = shift_pkg::WIDTH_DEF,
  parameter int unsigned AMT_W = shift_pkg::AMT_W_DEF
) ();

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [AMT_W-1:0] x;
  logic [AMT_W-1:0] y;
  logic [AMT_W-1:0] z;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, data_in, x, y, z,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, data_in, x, y, z,
    output ready, busy, done, result
  );

endinterface

// File: rtl/shift_phase_counter.sv
// Per-phase shift count: load, decrement, and zero flag.
module shift_phase_counter #(
  parameter int unsigned AMT_W = shift_pkg::AMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [AMT_W-1:0] load_val,
  input  logic             dec,
  output logic [AMT_W-1:0] cnt,
  output logic             zero_c
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - AMT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/shift_sequencer.sv
// One-bit-per-cycle shifter: left by x, logical right by y, left by z.
module shift_sequencer #(
  parameter int unsigned WIDTH = shift_pkg::WIDTH_DEF,
  parameter int unsigned AMT_W = shift_pkg::AMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_sequencer_if.slave bus
);

  import shift_pkg::*;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] result_next;
  logic [AMT_W-1:0] ry;
  logic [AMT_W-1:0] rz;
  logic [AMT_W-1:0] cnt;
  logic [AMT_W-1:0] cnt_load_val;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero_c;
  logic             accept;

  assign accept = (state == IDLE) && bus.start;

  shift_phase_counter #(.AMT_W(AMT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero_c   (cnt_zero_c)
  );

  // Status flags are registered from the next state so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      ry         <= '0;
      rz         <= '0;
      bus.result <= '0;
      bus.ready  <= 1'b1;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      state      <= state_next;
      acc        <= acc_next;
      bus.result <= result_next;
      bus.ready  <= (state_next == IDLE);
      bus.busy   <= (state_next != IDLE);
      bus.done   <= (state_next == DONE);
      if (accept) begin
        ry <= bus.y;
        rz <= bus.z;
      end
    end
  end

  always_comb begin
    state_next   = state;
    acc_next     = acc;
    result_next  = bus.result;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next   = SHL1;
          acc_next     = bus.data_in;
          cnt_load     = 1'b1;
          cnt_load_val = bus.x;
        end
      end
      SHL1: begin
        if (!cnt_zero_c) begin
          acc_next = {acc[WIDTH-2:0], 1'b0};
          cnt_dec  = 1'b1;
        end else begin
          state_next   = SHR;
          cnt_load     = 1'b1;
          cnt_load_val = ry;
        end
      end
      SHR: begin
        if (!cnt_zero_c) begin
          acc_next = {1'b0, acc[WIDTH-1:1]};
          cnt_dec  = 1'b1;
        end else begin
          state_next   = SHL2;
          cnt_load     = 1'b1;
          cnt_load_val = rz;
        end
      end
      SHL2: begin
        if (!cnt_zero_c) begin
          acc_next = {acc[WIDTH-2:0], 1'b0};
          cnt_dec  = 1'b1;
        end else begin
          state_next  = DONE;
          result_next = acc;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule
